mod_add_scheduler: RTL and testbench

Round-robin scheduler that shares one `modular_adder` instance between two requesters. Each requester offers an operand pair with a valid/ready handshake. The scheduler grants at most one pair per cycle and issues it to the adder. It tracks each in-flight operation through a tag pipeline matched to the adder latency, then returns the result with the originating requester ID. It sits between NTT butterfly/accumulation stages and the modular arithmetic datapath.

---
 rtl/ntt_pkg.sv | 16 +
 rtl/mod_add_scheduler_if.sv | 36 +++
 rtl/modular_adder.sv | 35 +++
 rtl/rr_arbiter2.sv | 32 +++
 rtl/mod_add_scheduler.sv | 102 ++++++++++
 tb/tb_mod_add_scheduler.sv | 158 +++++++++++++++
 6 files changed

// File: rtl/ntt_pkg.sv
// Shared NTT datapath types and constants.
// Used by mod_add_scheduler and its modular adder.
package ntt_pkg;

  localparam int NTT_Q = 1068564481;
  localparam int NTT_W = 30;

  typedef logic [NTT_W-1:0] coeff_t;
  typedef logic             req_id_t;

  typedef struct packed {
    logic    v;
    req_id_t id;
  } tag_t;

endpackage

// File: rtl/mod_add_scheduler_if.sv
// Two-requester operand bus plus result bus of mod_add_scheduler.
// master = requesters/consumer side, slave = scheduler side.
interface mod_add_scheduler_if #(
  parameter int W = 30
);

  logic         req0_valid;
  logic         req0_ready;
  logic [W-1:0] req0_a;
  logic [W-1:0] req0_b;
  logic         req1_valid;
  logic         req1_ready;
  logic [W-1:0] req1_a;
  logic [W-1:0] req1_b;
  logic         res_valid;
  logic         res_id;
  logic [W-1:0] res_c;
  logic         range_err;

  modport master (
    output req0_valid, req0_a, req0_b,
    output req1_valid, req1_a, req1_b,
    input  req0_ready, req1_ready,
    input  res_valid, res_id, res_c,
    input  range_err
  );

  modport slave (
    input  req0_valid, req0_a, req0_b,
    input  req1_valid, req1_a, req1_b,
    output req0_ready, req1_ready,
    output res_valid, res_id, res_c,
    output range_err
  );

endinterface

// File: rtl/modular_adder.sv
// (a+b) mod Q with a LAT-deep output pipeline.
// Operands are assumed < Q; no reset on the datapath.
module modular_adder #(
  parameter int Q   = 1068564481,
  parameter int W   = 30,
  parameter int LAT = 1
) (
  input  logic         clk,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] c
);

  localparam logic [W:0] QW = (W+1)'(Q);

  logic [W:0]   s;
  logic [W:0]   d;
  logic [W-1:0] r;
  logic [W-1:0] pipe [LAT];

  always_comb begin
    s = {1'b0, a} + {1'b0, b};
    d = s - QW;
    r = (s >= QW) ? d[W-1:0] : s[W-1:0];
  end

  always_ff @(posedge clk) begin
    pipe[0] <= r;
    for (int i = 1; i < LAT; i++)
      pipe[i] <= pipe[i-1];
  end

  assign c = pipe[LAT-1];

endmodule

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter with registered priority pointer.
// Pointer moves past the winner; readies forced low in reset.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  output logic [1:0] grant,
  output logic       prio
);

  always_comb begin
    grant = 2'b00;
    if (!rst) begin
      unique case (1'b1)
        valid == 2'b11: grant = prio ? 2'b10 : 2'b01;
        valid == 2'b01: grant = 2'b01;
        valid == 2'b10: grant = 2'b10;
        default:        grant = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      prio <= 1'b0;
    else if (grant[0])
      prio <= 1'b1;
    else if (grant[1])
      prio <= 1'b0;
  end

endmodule

// File: rtl/mod_add_scheduler.sv
// Shares one modular_adder between two requesters, round-robin.
// MOD_ADD_SCHED_RANGE_CHECK_EN adds a sticky operand range flag.
module mod_add_scheduler
  import ntt_pkg::*;
#(
  parameter int Q   = NTT_Q,
  parameter int W   = NTT_W,
  parameter int LAT = 1
) (
  input logic               clk,
  input logic               rst,
  mod_add_scheduler_if.slave bus
);

  logic [1:0]   gnt;
  logic         prio;
  logic         xfer;
  req_id_t      gid;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  tag_t         tags [LAT];

  rr_arbiter2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .valid ({bus.req1_valid, bus.req0_valid}),
    .grant (gnt),
    .prio  (prio)
  );

  assign bus.req0_ready = gnt[0];
  assign bus.req1_ready = gnt[1];
  assign xfer = |gnt;

  // Contended cycles resolve by the pointer, otherwise by who is asking.
  assign gid = (bus.req0_valid & bus.req1_valid) ? prio : bus.req1_valid;

  always_comb begin
    op_a = '0;
    op_b = '0;
    unique case (1'b1)
      gnt[0]: begin
        op_a = bus.req0_a;
        op_b = bus.req0_b;
      end
      gnt[1]: begin
        op_a = bus.req1_a;
        op_b = bus.req1_b;
      end
      default: begin
        op_a = '0;
        op_b = '0;
      end
    endcase
  end

  modular_adder #(
    .Q   (Q),
    .W   (W),
    .LAT (LAT)
  ) u_add (
    .clk (clk),
    .a   (op_a),
    .b   (op_b),
    .c   (bus.res_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++)
        tags[i] <= '0;
    end else begin
      tags[0] <= '{v: xfer, id: xfer ? gid : 1'b0};
      for (int i = 1; i < LAT; i++)
        tags[i] <= tags[i-1];
    end
  end

  assign bus.res_valid = tags[LAT-1].v;
  assign bus.res_id    = tags[LAT-1].id;

`ifdef MOD_ADD_SCHED_RANGE_CHECK_EN
  localparam logic [W:0] QW = (W+1)'(Q);

  logic bad_op;
  logic err_q;

  assign bad_op = ({1'b0, op_a} >= QW) | ({1'b0, op_b} >= QW);

  always_ff @(posedge clk) begin
    if (rst)
      err_q <= 1'b0;
    else if (xfer && bad_op)
      err_q <= 1'b1;
  end

  assign bus.range_err = err_q;
`else
  assign bus.range_err = 1'b0;
`endif

endmodule

// File: tb/tb_mod_add_scheduler.sv
// Directed bench for mod_add_scheduler (LAT=1).
// Honours MOD_ADD_SCHED_RANGE_CHECK_EN for the range_err step.
module tb_mod_add_scheduler;

  localparam int Q = 1068564481;
  localparam int W = 30;

`ifdef MOD_ADD_SCHED_RANGE_CHECK_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  mod_add_scheduler_if #(.W(W)) bus ();

  mod_add_scheduler #(
    .Q   (Q),
    .W   (W),
    .LAT (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v0, input logic [W-1:0] a0,
                       input logic [W-1:0] b0, input logic v1,
                       input logic [W-1:0] a1, input logic [W-1:0] b1);
    bus.req0_valid = v0;
    bus.req0_a     = a0;
    bus.req0_b     = b0;
    bus.req1_valid = v1;
    bus.req1_a     = a1;
    bus.req1_b     = b1;
    #1;
  endtask

  task automatic chk_res(input string tag, input logic v,
                         input logic id, input logic [W-1:0] c);
    chk({tag, "_v"}, 32'(bus.res_valid), 32'(v));
    chk({tag, "_id"}, 32'(bus.res_id), 32'(id));
    chk({tag, "_c"}, 32'(bus.res_c), 32'(c));
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b1, 30'd1, 30'd2, 1'b1, 30'd3, 30'd4);
    chk("rst_rdy0", 32'(bus.req0_ready), 32'd0);
    chk("rst_rdy1", 32'(bus.req1_ready), 32'd0);
    cyc();
    cyc();
    chk("rst_resv", 32'(bus.res_valid), 32'd0);
    chk("rst_err", 32'(bus.range_err), 32'd0);
    cyc();
    rst = 1'b0;
    drive(1'b0, 30'd0, 30'd0, 1'b0, 30'd0, 30'd0);

    for (int i = 0; i < 3; i++) begin
      chk("idle_rdy0", 32'(bus.req0_ready), 32'd0);
      chk("idle_rdy1", 32'(bus.req1_ready), 32'd0);
      chk_res("idle", 1'b0, 1'b0, 30'd0);
      cyc();
    end

    // wrap to zero; prio -> 1
    drive(1'b1, 30'(Q-1), 30'd1, 1'b0, 30'd0, 30'd0);
    chk("wrap_rdy0", 32'(bus.req0_ready), 32'd1);
    chk("wrap_rdy1", 32'(bus.req1_ready), 32'd0);
    cyc();
    drive(1'b0, 30'd0, 30'd0, 1'b0, 30'd0, 30'd0);
    chk_res("wrap", 1'b1, 1'b0, 30'd0);

    // prio=1 but only req0 asks; prio stays 1
    drive(1'b1, 30'd5, 30'd7, 1'b0, 30'd0, 30'd0);
    chk("solo0_rdy0", 32'(bus.req0_ready), 32'd1);
    cyc();
    drive(1'b1, 30'd10, 30'd20, 1'b1, 30'd1, 30'd1);
    chk_res("solo0", 1'b1, 1'b0, 30'd12);
    chk("prio1_rdy0", 32'(bus.req0_ready), 32'd0);
    chk("prio1_rdy1", 32'(bus.req1_ready), 32'd1);
    cyc();
    chk_res("prio1", 1'b1, 1'b1, 30'd2);

    // prio=0 now: contended grants 0,1,0,1
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 30'd10, 30'd20, 1'b1, 30'(Q-1), 30'(Q-1));
      chk("alt_rdy0", 32'(bus.req0_ready), 32'(i % 2 == 0));
      chk("alt_rdy1", 32'(bus.req1_ready), 32'(i % 2 == 1));
      cyc();
      if (i % 2 == 0)
        chk_res("alt0", 1'b1, 1'b0, 30'd30);
      else
        chk_res("alt1", 1'b1, 1'b1, 30'd1068564479);
    end
    drive(1'b0, 30'd0, 30'd0, 1'b0, 30'd0, 30'd0);
    cyc();
    chk("drain_v", 32'(bus.res_valid), 32'd0);

    // grant then reset: op dropped, prio back to 0
    drive(1'b1, 30'd2, 30'd3, 1'b0, 30'd0, 30'd0);
    cyc();
    rst = 1'b1;
    drive(1'b0, 30'd0, 30'd0, 1'b1, 30'd9, 30'd9);
    chk("mid_rst_rdy1", 32'(bus.req1_ready), 32'd0);
    cyc();
    chk("mid_rst_v", 32'(bus.res_valid), 32'd0);
    rst = 1'b0;
    drive(1'b1, 30'd4, 30'd4, 1'b1, 30'd6, 30'd6);
    chk("post_rst_rdy0", 32'(bus.req0_ready), 32'd1);
    chk("post_rst_rdy1", 32'(bus.req1_ready), 32'd0);
    cyc();
    drive(1'b0, 30'd0, 30'd0, 1'b0, 30'd0, 30'd0);
    chk_res("post_rst", 1'b1, 1'b0, 30'd8);

    // out-of-range operand from req1
    drive(1'b0, 30'd0, 30'd0, 1'b1, 30'(Q), 30'd0);
    chk("oor_rdy1", 32'(bus.req1_ready), 32'd1);
    chk("oor_err_pre", 32'(bus.range_err), 32'd0);
    cyc();
    drive(1'b0, 30'd0, 30'd0, 1'b0, 30'd0, 30'd0);
    chk("oor_v", 32'(bus.res_valid), 32'd1);
    chk("oor_id", 32'(bus.res_id), 32'd1);
    chk("oor_err", 32'(bus.range_err), 32'(ERR_EXP));
    cyc();
    cyc();
    chk("oor_err_hold", 32'(bus.range_err), 32'(ERR_EXP));
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("oor_err_clr", 32'(bus.range_err), 32'd0);
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
